reg_bank_bus_scheduler: RTL and testbench

Tick-paced round-robin scheduler that shares a bank of preset/reset flip-flop registers between several requesters over one write-data bus and one tri-state read bus. It sits between the datapath engines and the register bank. For each granted access it drives exactly one register's ClockEnable for a write, or exactly one register's cs low for a read. It returns a per-requester acknowledge. The register bank, including its Tick, pre and per-register Reset, is outside this block; the scheduler only drives ClockEnable, D and cs.

---
 rtl/reg_bank_bus_scheduler_if.sv | 28 ++
 rtl/reg_bank_bus_scheduler.sv | 146 ++++++++++++++
 tb/tb_reg_bank_bus_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank_bus_scheduler_if.sv
// ---------------------------------------------------------------------------
// reg_bank_bus_scheduler_if
// Requester-side handshake bundle of the register bank bus scheduler.
//   Req   : per-requester access request (level)
//   Wr    : per-requester direction, 1 = write, 0 = read
//   Addr  : per-requester register address, requester i at [i*RegAddrBits +: RegAddrBits]
//   WData : per-requester write data, requester i at [i*NrOfBits +: NrOfBits]
//   Gnt   : one-hot grant (ACCESS and DONE)
//   Ack   : one-hot completion (DONE)
//   Err   : out-of-range address flag, valid with Ack
// master = requester side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface reg_bank_bus_scheduler_if #(
   parameter int NrOfReq     = 4,
   parameter int RegAddrBits = 3,
   parameter int NrOfBits    = 8
);
   logic [NrOfReq-1:0]             Req;
   logic [NrOfReq-1:0]             Wr;
   logic [NrOfReq*RegAddrBits-1:0] Addr;
   logic [NrOfReq*NrOfBits-1:0]    WData;
   logic [NrOfReq-1:0]             Gnt;
   logic [NrOfReq-1:0]             Ack;
   logic                           Err;

   modport master (output Req, Wr, Addr, WData, input Gnt, Ack, Err);
   modport slave  (input Req, Wr, Addr, WData, output Gnt, Ack, Err);
endinterface

// File: rtl/reg_bank_bus_scheduler.sv
// ---------------------------------------------------------------------------
// reg_bank_bus_scheduler
// Tick-paced round-robin scheduler sharing a preset/reset register bank
// between several requesters over one write-data bus and one tri-state
// read bus. Each granted access drives exactly one ClockEnable (write) or
// exactly one cs low (read), then acknowledges the requester.
// Ports:
//   Clock          : system clock, rising edge
//   Reset          : asynchronous, active-high
//   Tick           : global enable shared with the register bank
//   bus            : requester handshake (Req/Wr/Addr/WData in, Gnt/Ack/Err out)
//   RegClockEnable : per-register ClockEnable, at most one bit set
//   RegD           : shared write data to every register D
//   RegCs          : per-register output disable, 1 = high-Z
//   Busy           : high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module reg_bank_bus_scheduler #(
   parameter int NrOfReq     = 4,
   parameter int NrOfRegs    = 8,
   parameter int RegAddrBits = 3,
   parameter int NrOfBits    = 8
) (
   input  logic                    Clock,
   input  logic                    Reset,
   input  logic                    Tick,
   reg_bank_bus_scheduler_if.slave bus,
   output logic [NrOfRegs-1:0]     RegClockEnable,
   output logic [NrOfBits-1:0]     RegD,
   output logic [NrOfRegs-1:0]     RegCs,
   output logic                    Busy
);

   localparam int IdxBits = (NrOfReq > 1) ? $clog2(NrOfReq) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t                  state;
   logic [IdxBits-1:0]      pointer;
   logic [RegAddrBits-1:0]  lat_addr;

   logic                    any_req;
   int                      win_num;
   logic [NrOfReq-1:0]      win_one_hot;
   logic                    win_wr;
   logic [RegAddrBits-1:0]  win_addr;
   logic [NrOfBits-1:0]     win_data;
   logic                    win_in_range;
   logic [NrOfRegs-1:0]     addr_one_hot;
   logic [IdxBits-1:0]      next_pointer;

   // Round-robin pick: offsets are scanned from the farthest back to the
   // pointer itself, so the requester closest above the pointer is the one
   // left standing. The winner's fields are then selected with constant
   // indices only.
   always_comb begin
      any_req      = 1'b0;
      win_num      = 0;
      win_one_hot  = '0;
      win_wr       = 1'b0;
      win_addr     = '0;
      win_data     = '0;
      addr_one_hot = '0;
      for (int k = NrOfReq - 1; k >= 0; k--) begin
         for (int i = 0; i < NrOfReq; i++) begin
            if (i == (int'(pointer) + k) % NrOfReq && bus.Req[i]) begin
               any_req = 1'b1;
               win_num = i;
            end
         end
      end
      for (int i = 0; i < NrOfReq; i++) begin
         if (i == win_num) begin
            win_one_hot[i] = 1'b1;
            win_wr         = bus.Wr[i];
            win_addr       = bus.Addr[i*RegAddrBits +: RegAddrBits];
            win_data       = bus.WData[i*NrOfBits +: NrOfBits];
         end
      end
      win_in_range = (int'(win_addr) < NrOfRegs);
      for (int r = 0; r < NrOfRegs; r++) begin
         addr_one_hot[r] = (int'(win_addr) == r);
      end
      next_pointer = IdxBits'((win_num + 1) % NrOfReq);
   end

   // Scheduler FSM with registered Moore outputs. The register strobes are
   // loaded on entry to ACCESS from the latched request, so nothing on the
   // bank side ever follows Req/Wr/Addr combinationally, and changes after
   // the grant cannot reach the bank. Reset clears the strobes immediately,
   // so a write interrupted mid-ACCESS never lands.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state          <= IDLE;
         pointer        <= '0;
         lat_addr       <= '0;
         bus.Gnt        <= '0;
         bus.Ack        <= '0;
         bus.Err        <= 1'b0;
         RegClockEnable <= '0;
         RegCs          <= '1;
         RegD           <= '0;
      end else if (Tick) begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state    <= ACCESS;
                  pointer  <= next_pointer;
                  lat_addr <= win_addr;
                  bus.Gnt  <= win_one_hot;
                  if (win_wr) begin
                     RegD <= win_data;
                     if (win_in_range) begin
                        RegClockEnable <= addr_one_hot;
                     end
                  end else if (win_in_range) begin
                     RegCs <= ~addr_one_hot;
                  end
               end
            end
            ACCESS: begin
               state          <= DONE;
               bus.Ack        <= bus.Gnt;
               bus.Err        <= (int'(lat_addr) >= NrOfRegs);
               RegClockEnable <= '0;
               RegCs          <= '1;
            end
            DONE: begin
               state   <= IDLE;
               bus.Gnt <= '0;
               bus.Ack <= '0;
               bus.Err <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign Busy = (state != IDLE);

endmodule

// File: tb/tb_reg_bank_bus_scheduler.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_bus_scheduler
// Self-checking bench: drives the scheduler with directed and $urandom
// transactions, models the register bank it controls, and predicts grants,
// strobes, acknowledges and read data from a transaction-level model
// (round-robin pointer + expected register contents).
// ---------------------------------------------------------------------------
module tb_reg_bank_bus_scheduler;

   localparam int NR    = 4;
   localparam int NREGS = 6;
   localparam int AB    = 3;
   localparam int DB    = 8;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             Tick;
   logic [NREGS-1:0] RegClockEnable;
   logic [DB-1:0]    RegD;
   logic [NREGS-1:0] RegCs;
   logic             Busy;

   reg_bank_bus_scheduler_if #(.NrOfReq(NR), .RegAddrBits(AB), .NrOfBits(DB)) bus ();

   reg_bank_bus_scheduler #(
      .NrOfReq(NR), .NrOfRegs(NREGS), .RegAddrBits(AB), .NrOfBits(DB)
   ) dut (
      .Clock(Clock), .Reset(Reset), .Tick(Tick), .bus(bus),
      .RegClockEnable(RegClockEnable), .RegD(RegD), .RegCs(RegCs), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   int total = 0;
   int bad   = 0;

   // Register bank driven by the scheduler (its own reset is not used here)
   logic [DB-1:0] bankQ [NREGS] = '{default: '0};
   logic [DB-1:0] busVal;

   // Transaction-level expectations
   logic [DB-1:0] mem [NREGS] = '{default: '0};
   int            rrPtr = 0;

   // Bank registers capture D on a Tick edge while their ClockEnable is set
   always @(posedge Clock) begin
      if (Tick) begin
         for (int r = 0; r < NREGS; r++) begin
            if (RegClockEnable[r]) bankQ[r] <= RegD;
         end
      end
   end

   // Tri-state read bus resolved as a mux of the selected register
   always_comb begin
      busVal = '0;
      for (int r = 0; r < NREGS; r++) begin
         if (!RegCs[r]) busVal = bankQ[r];
      end
   end

   // Bank-side exclusivity must hold on every cycle
   always @(negedge Clock) begin
      total++;
      if (!($countones(RegClockEnable) <= 1 && $countones(~RegCs) <= 1 &&
            !((|RegClockEnable) && !(&RegCs)))) begin
         bad++;
         $display("[TB] FAIL invariant: ce=%b cs=%b required at most one strobe", RegClockEnable, RegCs);
      end
   end

   typedef struct {
      bit               timedOut;
      int               waitCycles;
      logic [NR-1:0]    gntA;
      logic [NREGS-1:0] ceA;
      logic [NREGS-1:0] csA;
      logic [DB-1:0]    dA;
      logic [DB-1:0]    busA;
      logic [NR-1:0]    ackD;
      logic             errD;
      logic [NREGS-1:0] ceD;
      logic [NREGS-1:0] csD;
      logic [NR-1:0]    ackI;
      logic             busyI;
   } obs_t;

   function automatic int rr_pick(input int ptr, input logic [NR-1:0] mask);
      for (int k = 0; k < NR; k++) begin
         if (mask[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [NR-1:0] one_hot_req(input int w);
      logic [NR-1:0] v;
      v = '0;
      for (int i = 0; i < NR; i++) if (i == w) v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [NREGS-1:0] exp_ce(input bit wr, input int addr);
      logic [NREGS-1:0] v;
      v = '0;
      for (int r = 0; r < NREGS; r++) if (wr && r == addr) v[r] = 1'b1;
      return v;
   endfunction

   function automatic logic [NREGS-1:0] exp_cs(input bit wr, input int addr);
      logic [NREGS-1:0] v;
      v = '1;
      for (int r = 0; r < NREGS; r++) if (!wr && r == addr) v[r] = 1'b0;
      return v;
   endfunction

   task automatic set_req(input int r, input bit wr, input int addr, input logic [DB-1:0] data);
      logic [AB-1:0] a;
      a = addr[AB-1:0];
      for (int i = 0; i < NR; i++) begin
         if (i == r) begin
            bus.Wr[i]                = wr;
            bus.Addr[i*AB +: AB]     = a;
            bus.WData[i*DB +: DB]    = data;
         end
      end
   endtask

   // Waits for a grant (bounded), drops all requests, and records what the
   // scheduler shows in ACCESS, DONE and the following IDLE cycle.
   task automatic capture_txn(output obs_t o);
      int k;
      o = '{default: '0};
      k = 0;
      do begin
         @(negedge Clock);
         k++;
      end while (bus.Gnt == '0 && k < 40);
      o.waitCycles = k;
      if (bus.Gnt == '0) begin
         o.timedOut = 1'b1;
         bus.Req = '0;
         return;
      end
      o.gntA = bus.Gnt;
      o.ceA  = RegClockEnable;
      o.csA  = RegCs;
      o.dA   = RegD;
      o.busA = busVal;
      bus.Req = '0;
      @(negedge Clock);
      o.ackD = bus.Ack;
      o.errD = bus.Err;
      o.ceD  = RegClockEnable;
      o.csD  = RegCs;
      @(negedge Clock);
      o.ackI  = bus.Ack;
      o.busyI = Busy;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge Clock);
         if (!Busy && bus.Ack == '0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      obs_t o;
      int   k;
      Reset = 1'b1;
      Tick  = 1'b1;
      repeat (2) @(negedge Clock);
      total++; if (bus.Gnt !== '0) begin bad++; $display("[TB] FAIL reset_gnt: got %b want 0", bus.Gnt); end
      total++; if (bus.Ack !== '0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", bus.Ack); end
      total++; if (bus.Err !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", bus.Err); end
      total++; if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", Busy); end
      total++; if (RegClockEnable !== '0) begin bad++; $display("[TB] FAIL reset_ce: got %b want 0", RegClockEnable); end
      total++; if (RegCs !== '1) begin bad++; $display("[TB] FAIL reset_cs: got %b want all 1", RegCs); end
      total++; if (RegD !== '0) begin bad++; $display("[TB] FAIL reset_d: got %h want 0", RegD); end
      Reset = 1'b0;
      rrPtr = 0;

      // Establish a known value in reg 2
      set_req(0, 1'b1, 2, 8'h3C);
      bus.Req = 4'b0001;
      capture_txn(o);
      total++; if (o.timedOut || o.ceA !== exp_ce(1'b1, 2)) begin bad++; $display("[TB] FAIL reset_prewrite_ce: got %b want %b", o.ceA, exp_ce(1'b1, 2)); end
      mem[2] = 8'h3C;
      rrPtr  = 1;

      // Interrupt a write to reg 2 while it is in ACCESS
      set_req(1, 1'b1, 2, 8'hFF);
      bus.Req = 4'b0010;
      k = 0;
      do begin
         @(negedge Clock);
         k++;
      end while (bus.Gnt == '0 && k < 20);
      total++; if (bus.Gnt !== 4'b0010) begin bad++; $display("[TB] FAIL reset_mid_gnt: got %b want 0010", bus.Gnt); end
      total++; if (RegClockEnable !== exp_ce(1'b1, 2)) begin bad++; $display("[TB] FAIL reset_mid_ce: got %b want %b", RegClockEnable, exp_ce(1'b1, 2)); end
      #2 Reset = 1'b1;
      #1;
      total++; if (RegClockEnable !== '0) begin bad++; $display("[TB] FAIL reset_async_ce: got %b want 0", RegClockEnable); end
      total++; if (RegCs !== '1) begin bad++; $display("[TB] FAIL reset_async_cs: got %b want all 1", RegCs); end
      total++; if (bus.Gnt !== '0) begin bad++; $display("[TB] FAIL reset_async_gnt: got %b want 0", bus.Gnt); end
      total++; if (Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_async_busy: got %b want 0", Busy); end
      bus.Req = '0;
      @(negedge Clock);
      Reset = 1'b0;
      rrPtr = 0;

      // Reg 2 must still hold its old value
      set_req(2, 1'b0, 2, 8'h00);
      bus.Req = 4'b0100;
      capture_txn(o);
      total++; if (o.timedOut || o.busA !== mem[2]) begin bad++; $display("[TB] FAIL reset_no_partial_write: got %h want %h", o.busA, mem[2]); end
      rrPtr = 3;
   endtask

   task automatic test_write_read;
      obs_t o;
      set_req(0, 1'b1, 3, 8'hA5);
      bus.Req = 4'b0001;
      capture_txn(o);
      total++; if (o.timedOut || o.waitCycles != 1) begin bad++; $display("[TB] FAIL wr_latency: got %0d want 1", o.waitCycles); end
      total++; if (o.gntA !== 4'b0001) begin bad++; $display("[TB] FAIL wr_gnt: got %b want 0001", o.gntA); end
      total++; if (o.ceA !== 6'b001000) begin bad++; $display("[TB] FAIL wr_ce: got %b want 001000", o.ceA); end
      total++; if (o.dA !== 8'hA5) begin bad++; $display("[TB] FAIL wr_d: got %h want a5", o.dA); end
      total++; if (o.csA !== '1) begin bad++; $display("[TB] FAIL wr_cs: got %b want all 1", o.csA); end
      total++; if (o.ackD !== 4'b0001 || o.errD !== 1'b0) begin bad++; $display("[TB] FAIL wr_ack: got ack=%b err=%b want 0001/0", o.ackD, o.errD); end
      total++; if (o.ceD !== '0) begin bad++; $display("[TB] FAIL wr_ce_done: got %b want 0", o.ceD); end
      total++; if (o.ackI !== '0 || o.busyI !== 1'b0) begin bad++; $display("[TB] FAIL wr_idle: got ack=%b busy=%b want 0/0", o.ackI, o.busyI); end
      mem[3] = 8'hA5;
      rrPtr  = 1;

      set_req(0, 1'b0, 3, 8'h00);
      bus.Req = 4'b0001;
      capture_txn(o);
      total++; if (o.timedOut || o.csA !== 6'b110111) begin bad++; $display("[TB] FAIL rd_cs: got %b want 110111", o.csA); end
      total++; if (o.ceA !== '0) begin bad++; $display("[TB] FAIL rd_ce: got %b want 0", o.ceA); end
      total++; if (o.busA !== 8'hA5) begin bad++; $display("[TB] FAIL rd_data: got %h want a5", o.busA); end
      total++; if (o.ackD !== 4'b0001) begin bad++; $display("[TB] FAIL rd_ack: got %b want 0001", o.ackD); end
      total++; if (o.csD !== '1) begin bad++; $display("[TB] FAIL rd_cs_done: got %b want all 1", o.csD); end
      rrPtr = 1;
   endtask

   task automatic test_out_of_range;
      obs_t o;
      set_req(1, 1'b1, 7, 8'h99);
      bus.Req = 4'b0010;
      capture_txn(o);
      total++; if (o.timedOut || o.ceA !== '0) begin bad++; $display("[TB] FAIL oor_wr_ce: got %b want 0", o.ceA); end
      total++; if (o.csA !== '1) begin bad++; $display("[TB] FAIL oor_wr_cs: got %b want all 1", o.csA); end
      total++; if (o.ackD !== 4'b0010 || o.errD !== 1'b1) begin bad++; $display("[TB] FAIL oor_wr_ack: got ack=%b err=%b want 0010/1", o.ackD, o.errD); end
      total++; if (o.ackI !== '0) begin bad++; $display("[TB] FAIL oor_err_clear: got ack=%b want 0", o.ackI); end
      rrPtr = 2;

      set_req(2, 1'b0, 6, 8'h00);
      bus.Req = 4'b0100;
      capture_txn(o);
      total++; if (o.timedOut || o.csA !== '1) begin bad++; $display("[TB] FAIL oor_rd_cs: got %b want all 1", o.csA); end
      total++; if (o.ackD !== 4'b0100 || o.errD !== 1'b1) begin bad++; $display("[TB] FAIL oor_rd_ack: got ack=%b err=%b want 0100/1", o.ackD, o.errD); end
      rrPtr = 3;
   endtask

   task automatic test_abort;
      obs_t o;
      int   k;
      set_req(3, 1'b1, 1, 8'h5A);
      bus.Req = 4'b1000;
      k = 0;
      do begin
         @(negedge Clock);
         k++;
      end while (bus.Gnt == '0 && k < 20);
      total++; if (bus.Gnt !== 4'b1000) begin bad++; $display("[TB] FAIL abort_gnt: got %b want 1000", bus.Gnt); end
      bus.Req = '0;
      set_req(3, 1'b0, 4, 8'h00);
      @(negedge Clock);
      total++; if (bus.Ack !== 4'b1000) begin bad++; $display("[TB] FAIL abort_ack: got %b want 1000", bus.Ack); end
      @(negedge Clock);
      mem[1] = 8'h5A;
      rrPtr  = 0;

      set_req(0, 1'b0, 1, 8'h00);
      set_req(3, 1'b1, 4, 8'h77);
      bus.Req = 4'b1001;
      capture_txn(o);
      total++; if (o.timedOut || o.gntA !== one_hot_req(rr_pick(rrPtr, 4'b1001))) begin bad++; $display("[TB] FAIL abort_wrap_gnt: got %b want %b", o.gntA, one_hot_req(rr_pick(rrPtr, 4'b1001))); end
      total++; if (o.busA !== mem[1]) begin bad++; $display("[TB] FAIL abort_write_landed: got %h want %h", o.busA, mem[1]); end
      rrPtr = 1;

      set_req(1, 1'b0, 4, 8'h00);
      bus.Req = 4'b0010;
      capture_txn(o);
      total++; if (o.timedOut || o.busA !== mem[4]) begin bad++; $display("[TB] FAIL abort_addr_change_ignored: got %h want %h", o.busA, mem[4]); end
      rrPtr = 2;
   endtask

   task automatic test_round_robin;
      logic [NR-1:0] expG;
      int            k;
      int            w;
      bit            ok;
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      rrPtr = 0;
      for (int r = 0; r < NR; r++) set_req(r, 1'b0, r, 8'h00);
      bus.Req = '1;
      for (int g = 0; g < 5; g++) begin
         k = 0;
         do begin
            @(negedge Clock);
            k++;
         end while (bus.Gnt == '0 && k < 10);
         w     = rr_pick(rrPtr, 4'b1111);
         rrPtr = (w + 1) % NR;
         expG  = one_hot_req(w);
         total++; if (bus.Gnt !== expG) begin bad++; $display("[TB] FAIL rr_order%0d: got %b want %b", g, bus.Gnt, expG); end
         total++; if (k != ((g == 0) ? 1 : 2)) begin bad++; $display("[TB] FAIL rr_spacing%0d: got %0d want %0d", g, k, (g == 0) ? 1 : 2); end
         total++; if (bus.Ack !== '0) begin bad++; $display("[TB] FAIL rr_ack_low%0d: got %b want 0", g, bus.Ack); end
         @(negedge Clock);
         total++; if (bus.Ack !== expG) begin bad++; $display("[TB] FAIL rr_ack%0d: got %b want %b", g, bus.Ack, expG); end
      end
      bus.Req = '0;
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL rr_drain: got busy want idle"); end
   endtask

   task automatic test_random;
      obs_t          o;
      logic [NR-1:0] mask;
      bit            wrA   [NR];
      int            addrA [NR];
      logic [DB-1:0] dataA [NR];
      int            w;
      for (int t = 0; t < 40; t++) begin
         mask = NR'($urandom_range(1, 15));
         for (int r = 0; r < NR; r++) begin
            wrA[r]   = 1'($urandom_range(0, 1));
            addrA[r] = int'($urandom_range(0, 7));
            dataA[r] = DB'($urandom);
            set_req(r, wrA[r], addrA[r], dataA[r]);
         end
         bus.Req = mask;
         w = rr_pick(rrPtr, mask);
         capture_txn(o);
         total++; if (o.timedOut || o.gntA !== one_hot_req(w)) begin bad++; $display("[TB] FAIL rand_gnt%0d: got %b want %b", t, o.gntA, one_hot_req(w)); end
         total++; if (o.ceA !== exp_ce(wrA[w], addrA[w])) begin bad++; $display("[TB] FAIL rand_ce%0d: got %b want %b", t, o.ceA, exp_ce(wrA[w], addrA[w])); end
         total++; if (o.csA !== exp_cs(wrA[w], addrA[w])) begin bad++; $display("[TB] FAIL rand_cs%0d: got %b want %b", t, o.csA, exp_cs(wrA[w], addrA[w])); end
         if (wrA[w] && addrA[w] < NREGS) begin
            total++; if (o.dA !== dataA[w]) begin bad++; $display("[TB] FAIL rand_d%0d: got %h want %h", t, o.dA, dataA[w]); end
            mem[addrA[w]] = dataA[w];
         end
         if (!wrA[w] && addrA[w] < NREGS) begin
            total++; if (o.busA !== mem[addrA[w]]) begin bad++; $display("[TB] FAIL rand_rd%0d: got %h want %h", t, o.busA, mem[addrA[w]]); end
         end
         total++; if (o.ackD !== one_hot_req(w) || o.errD !== (addrA[w] >= NREGS)) begin bad++; $display("[TB] FAIL rand_ack%0d: got ack=%b err=%b want %b/%b", t, o.ackD, o.errD, one_hot_req(w), addrA[w] >= NREGS); end
         total++; if (o.ackI !== '0) begin bad++; $display("[TB] FAIL rand_ack_clear%0d: got %b want 0", t, o.ackI); end
         rrPtr = (w + 1) % NR;
      end
   endtask

   task automatic test_tick_gating;
      int  csLow  = 0;
      int  ackHi  = 0;
      int  gntHi  = 0;
      int  badBus = 0;
      bit  ok;
      set_req(2, 1'b0, 5, 8'h00);
      bus.Req = 4'b0100;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge Clock);
         if (!RegCs[5]) begin
            csLow++;
            if (busVal !== mem[5]) badBus++;
         end
         if (bus.Ack[2]) ackHi++;
         if (bus.Gnt[2]) begin
            gntHi++;
            bus.Req = '0;
         end
         Tick = (cyc % 4 == 3);
      end
      Tick = 1'b1;
      total++; if (csLow != 4) begin bad++; $display("[TB] FAIL tick_cs_cycles: got %0d want 4", csLow); end
      total++; if (ackHi != 4) begin bad++; $display("[TB] FAIL tick_ack_cycles: got %0d want 4", ackHi); end
      total++; if (gntHi != 8) begin bad++; $display("[TB] FAIL tick_gnt_cycles: got %0d want 8", gntHi); end
      total++; if (badBus != 0) begin bad++; $display("[TB] FAIL tick_rd_data: got %0d bad cycles want 0", badBus); end
      wait_idle(ok);
      total++; if (!ok) begin bad++; $display("[TB] FAIL tick_drain: got busy want idle"); end
      rrPtr = 3;
   endtask

   initial begin
      bus.Req   = '0;
      bus.Wr    = '0;
      bus.Addr  = '0;
      bus.WData = '0;
      Tick      = 1'b1;
      Reset     = 1'b1;
      $display("[TB] starting reg_bank_bus_scheduler bench");
      test_reset();
      test_write_read();
      test_out_of_range();
      test_abort();
      test_round_robin();
      test_random();
      test_tick_gating();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
